// File: rtl/fft64_in_buffer_if.sv
// Serial-in / parallel-out bus for the 64-point FFT input buffer.
// din_sof and sof_err exist only when FFT64_SOF_EN is defined.
interface fft64_in_buffer_if #(
  parameter int DATA_W = 34,
  parameter int N_PTS  = 64
);
  logic [DATA_W-1:0]        din;
  logic                     din_valid;
  logic                     din_ready;
  logic [DATA_W*N_PTS-1:0]  frame_data;
  logic                     frame_valid;
  logic                     frame_ready;
  logic [$clog2(N_PTS)-1:0] wr_cnt;
`ifdef FFT64_SOF_EN
  logic                     din_sof;
  logic                     sof_err;

  modport master (
    output din, din_valid, din_sof, frame_ready,
    input  din_ready, frame_data, frame_valid, wr_cnt, sof_err
  );
  modport slave (
    input  din, din_valid, din_sof, frame_ready,
    output din_ready, frame_data, frame_valid, wr_cnt, sof_err
  );
`else
  modport master (
    output din, din_valid, frame_ready,
    input  din_ready, frame_data, frame_valid, wr_cnt
  );
  modport slave (
    input  din, din_valid, frame_ready,
    output din_ready, frame_data, frame_valid, wr_cnt
  );
`endif
endinterface

// File: rtl/fft64_in_buffer.sv
// Collects 64 serial complex samples into one registered parallel frame for the butterfly stage.
// Optional start-of-frame realignment and sticky error flag: define FFT64_SOF_EN.
module fft64_in_buffer #(
  parameter int DATA_W = 34,
  parameter int N_PTS  = 64
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  fft64_in_buffer_if.slave  bus
);
  localparam int CNT_W = $clog2(N_PTS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_PTS - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t                  state_q, state_nxt;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_nxt;
  logic [CNT_W-1:0]        wr_slot;
  logic [DATA_W*N_PTS-1:0] frame_q;
  logic                    din_ready_q;
  logic                    frame_valid_q;
  logic                    accept;
  logic                    sof_hit;

  assign accept = bus.din_valid & din_ready_q;

`ifdef FFT64_SOF_EN
  logic sof_err_q;
  assign sof_hit = accept & bus.din_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // A start-of-frame sample always lands in slot 0, abandoning any partial frame.
  assign wr_slot = sof_hit ? '0 : wr_cnt_q;

  always_comb begin
    state_nxt  = state_q;
    wr_cnt_nxt = wr_cnt_q;
    if (accept)
      wr_cnt_nxt = sof_hit ? CNT_W'(1) : wr_cnt_q + 1'b1;
    case (state_q)
      FILL: if (accept && !sof_hit && wr_cnt_q == LAST_SLOT) state_nxt = FULL;
      FULL: if (frame_valid_q && bus.frame_ready)            state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Handshake outputs are registered copies of the next state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= FILL;
      wr_cnt_q      <= '0;
      din_ready_q   <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      wr_cnt_q      <= wr_cnt_nxt;
      din_ready_q   <= (state_nxt == FILL);
      frame_valid_q <= (state_nxt == FULL);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PTS; i++) begin
        if (accept && wr_slot == CNT_W'(i))
          frame_q[i*DATA_W +: DATA_W] <= bus.din;
      end
    end
  end

`ifdef FFT64_SOF_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      sof_err_q <= 1'b0;
    else if (sof_hit && wr_cnt_q != '0)
      sof_err_q <= 1'b1;
  end

  assign bus.sof_err = sof_err_q;
`endif

  assign bus.din_ready   = din_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_q;
  assign bus.wr_cnt      = wr_cnt_q;

endmodule

// File: doc/fft64_in_buffer.md
FFT64_IN_BUFFER -- requirements
Module: fft64_in_buffer

Interface
REQ-001 Parameter: DATA_W, 34, width of one complex sample: Re in [33:17], Im in [16:0], both two's complement.
REQ-002 Parameter: N_PTS, 64, samples per frame; fixed at 64 for this revision.
REQ-003 Port: sys_clk  input  1  single clock; all registers rise-edge.
REQ-004 Port: sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: din  input  34  serial complex sample in.
REQ-006 Port: din_valid  input  1  din is valid this cycle.
REQ-007 Port: din_ready  output  1  block accepts din this cycle.
REQ-008 Port: din_sof  input  1  start-of-frame marker; present only under FFT64_SOF_EN.
REQ-009 Port: frame_data  output  2176  parallel frame; sample k at [34k+33:34k], natural order, sample 0 at LSB.
REQ-010 Port: frame_valid  output  1  frame_data holds a complete 64-sample frame.
REQ-011 Port: frame_ready  input  1  downstream 64-point butterfly stage consumes frame.
REQ-012 Port: wr_cnt  output  6  index of the next sample slot.
REQ-013 Port: sof_err  output  1  sticky misaligned-SOF flag; present only under FFT64_SOF_EN.

Function
REQ-014 The block shall accept a sample only when din_valid and din_ready are both 1 on a rising edge.
REQ-015 An accepted sample shall be written to slot wr_cnt; wr_cnt shall then increment modulo 64 (63 -> 0).
REQ-016 The FSM shall have two states: FILL (din_ready=1, frame_valid=0) and FULL (din_ready=0, frame_valid=1).
REQ-017 FILL -> FULL shall occur on the edge that accepts the sample at slot 63; frame_valid shall be 1 in the next cycle.
REQ-018 FULL -> FILL shall occur on the edge where frame_valid and frame_ready are both 1; din_ready shall be 1 in the next cycle.
REQ-019 frame_ready sampled while in FILL shall have no effect.
REQ-020 din_valid sampled while in FULL shall be ignored; no slot shall change and wr_cnt shall hold 0.
REQ-021 frame_data shall be registered and bit-stable throughout FULL.
REQ-022 In FILL, only the slot being written shall change on any edge.
REQ-023 Minimum frame period shall be 65 cycles: 64 accepts plus 1 handshake cycle.
REQ-024 Data shall pass through unmodified, with no scaling, rounding or sign manipulation.
REQ-025 frame_valid, din_ready, wr_cnt and sof_err shall be driven directly from registers.

Reset
REQ-026 Asserting sys_rst_n low shall, asynchronously: set state to FILL; clear wr_cnt, all frame_data bits, frame_valid, din_ready and sof_err to 0.
REQ-027 din_ready shall become 1 on the first rising edge after sys_rst_n deasserts.
REQ-028 A reset during FILL or FULL shall discard the partial or pending frame; no frame_valid shall follow until 64 new accepts.

Configuration
REQ-029 Macro FFT64_SOF_EN, when defined, shall add the din_sof and sof_err ports.
REQ-030 With FFT64_SOF_EN defined, an accepted sample with din_sof=1 shall be written to slot 0 and wr_cnt shall become 1, discarding any partial frame.
REQ-031 With FFT64_SOF_EN defined, if wr_cnt != 0 when a din_sof=1 sample is accepted, sof_err shall set to 1 and stay 1 until reset.
REQ-032 With FFT64_SOF_EN defined, din_sof=1 with wr_cnt=0 shall be normal operation; din_sof=0 at wr_cnt=0 shall be accepted normally.
REQ-033 Without FFT64_SOF_EN, din_sof and sof_err shall be absent and framing shall rely solely on wr_cnt.

Verification
REQ-034 Reset release, then 64 accepts of din = k (k=0..63) with frame_ready=0 -> frame_valid=1 one cycle after the 64th accept; frame_data[34k+33:34k]=k; din_ready=0.
REQ-035 Hold FULL for 10 cycles with din_valid=1 and din=34'h3FFFFFFFF -> frame_data unchanged; wr_cnt=0; then assert frame_ready for 1 cycle -> frame_valid=0 and din_ready=1 next cycle.
REQ-036 Back-to-back frames with frame_ready=1 and din_valid=1 continuously -> frame_valid pulses once every 65 cycles; each frame's contents are correct.
REQ-037 din_valid toggling 1,0 every cycle across 64 accepts -> frame completes after 127 cycles with correct slot ordering.
REQ-038 Assert sys_rst_n=0 after 30 accepts, release, then send 64 samples -> frame_valid occurs only after the 64 new samples; frame_data holds only the new values.
REQ-039 With FFT64_SOF_EN defined: send 20 samples, then a din_sof=1 sample 34'h1_5555 -> sof_err=1, slot 0=34'h1_5555, wr_cnt=1; 63 further samples complete the frame.
